cam_param: RTL and testbench

- Parametrised content-addressable memory with per-entry valid bits, explicit invalidate, and a priority-encoded search reporting hit, index and multi-hit.
- Registered read and search ports, plus an occupancy count and a full flag.
- Drop-in successor to the fixed 32x32 CAM. Driven by the same bench-side clocking structure: outputs drive on posedge, inputs sample late in the cycle.

---
 rtl/cam_pkg.sv | 33 +++
 rtl/cam_prio_enc.sv | 34 +++
 rtl/cam_param.sv | 150 +++++++++++++++
 tb/tb_cam_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the parametrised CAM (cam_param):
//   CAM_DEPTH_DEF / CAM_WIDTH_DEF : default geometry (32 x 32)
//   CAM_IDX_MAX_W / CAM_VEC_MAX   : widest index / match vector supported (256 entries)
//   cam_search_rsp_t              : registered search response {valid, multi, index}
//   first_one()                   : lowest set bit of a match vector, bit 0 wins
// ---------------------------------------------------------------------------
package cam_pkg;

    localparam int CAM_DEPTH_DEF  = 32;
    localparam int CAM_WIDTH_DEF  = 32;
    localparam int CAM_IDX_MAX_W  = 8;
    localparam int CAM_VEC_MAX    = 256;

    typedef struct packed {
        logic                     valid;
        logic                     multi;
        logic [CAM_IDX_MAX_W-1:0] index;
    } cam_search_rsp_t;

    // Scanning downwards lets the lowest set bit overwrite any higher one,
    // which gives fixed priority with index 0 highest.
    function automatic logic [CAM_IDX_MAX_W-1:0] first_one(input logic [CAM_VEC_MAX-1:0] vec);
        logic [CAM_IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = CAM_VEC_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = CAM_IDX_MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// ---------------------------------------------------------------------------
// cam_prio_enc
// Combinational priority encoder for the CAM match vector.
//   match_i [N]          : one bit per entry that matched the key
//   hit_o                : at least one bit set
//   multi_o              : two or more bits set
//   index_o [$clog2(N)]  : lowest set bit (0 when nothing is set)
// ---------------------------------------------------------------------------
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]         match_i,
    output logic                 hit_o,
    output logic                 multi_o,
    output logic [$clog2(N)-1:0] index_o
);

    localparam int IW = $clog2(N);

    logic [CAM_VEC_MAX-1:0] match_ext;

    always_comb begin
        match_ext          = '0;
        match_ext[N-1:0]   = match_i;
    end

    assign hit_o   = |match_i;
    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign multi_o = |(match_i & (match_i - N'(1)));
    assign index_o = IW'(first_one(match_ext));

endmodule

// File: rtl/cam_param.sv
// ---------------------------------------------------------------------------
// cam_param
// Parametrised content-addressable memory with per-entry valid bits,
// explicit invalidate and a priority-encoded, registered search.
//
// Parameters: DEPTH (entries, power of two 2..256), WIDTH (1..128),
//             IDX_W = $clog2(DEPTH) (derived).
// Ports:
//   clk, rst (asynchronous, active-low)
//   read_i / read_index_i                   -> read_valid_o, read_value_o (1 cycle)
//   write_i / write_index_i / write_data_i  : sets entry valid
//   inval_i / inval_index_i                 : clears entry valid
//   search_i / search_data_i                -> search_valid_o, search_index_o,
//                                              search_multi_o (1 cycle)
//   count_o (valid entries), full_o (count_o == DEPTH, advisory only)
//
// Build option CAM_PARAM_MASK_EN adds search_mask_i: a 1 bit makes that
// key bit don't-care during the search.
// ---------------------------------------------------------------------------
module cam_param
    import cam_pkg::*;
#(
    parameter int  DEPTH = CAM_DEPTH_DEF,
    parameter int  WIDTH = CAM_WIDTH_DEF,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_i,
    input  logic [IDX_W-1:0] read_index_i,
    input  logic             write_i,
    input  logic [IDX_W-1:0] write_index_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic             inval_i,
    input  logic [IDX_W-1:0] inval_index_i,
    input  logic             search_i,
    input  logic [WIDTH-1:0] search_data_i,
`ifdef CAM_PARAM_MASK_EN
    input  logic [WIDTH-1:0] search_mask_i,
`endif
    output logic             read_valid_o,
    output logic [WIDTH-1:0] read_value_o,
    output logic             search_valid_o,
    output logic [IDX_W-1:0] search_index_o,
    output logic             search_multi_o,
    output logic [IDX_W:0]   count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             read_valid_q, read_valid_d;
    logic [WIDTH-1:0] read_value_q, read_value_d;
    cam_search_rsp_t  rsp_q, rsp_d;

    logic [DEPTH-1:0] match;
    logic             enc_hit, enc_multi;
    logic [IDX_W-1:0] enc_index;
    logic             cnt_inc, cnt_dec;
    logic [WIDTH-1:0] care_mask;

`ifdef CAM_PARAM_MASK_EN
    assign care_mask = ~search_mask_i;
`else
    assign care_mask = '1;
`endif

    // Match is taken from the registered array, so a same-cycle write is
    // not visible to the search (read-old).
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (((data_q[i] ^ search_data_i) & care_mask) == '0);
        end
    end

    cam_prio_enc #(.N(DEPTH)) u_prio_enc (
        .match_i (match),
        .hit_o   (enc_hit),
        .multi_o (enc_multi),
        .index_o (enc_index)
    );

    // Invalidate is applied first so a write to the same index wins.
    // The decrement is suppressed when the same entry is also written,
    // since the entry stays valid.
    always_comb begin
        valid_d = valid_q;
        if (inval_i) valid_d[inval_index_i] = 1'b0;
        if (write_i) valid_d[write_index_i] = 1'b1;

        cnt_inc = write_i && !valid_q[write_index_i];
        cnt_dec = inval_i && valid_q[inval_index_i] &&
                  !(write_i && (write_index_i == inval_index_i));
        count_d = count_q;
        if (cnt_inc && !cnt_dec) count_d = count_q + 1'b1;
        if (cnt_dec && !cnt_inc) count_d = count_q - 1'b1;
    end

    // Read and search responses; value/index hold when the port is idle.
    always_comb begin
        read_valid_d = 1'b0;
        read_value_d = read_value_q;
        if (read_i) begin
            read_valid_d = valid_q[read_index_i];
            read_value_d = valid_q[read_index_i] ? data_q[read_index_i] : '0;
        end

        rsp_d       = rsp_q;
        rsp_d.valid = 1'b0;
        rsp_d.multi = 1'b0;
        if (search_i) begin
            rsp_d.valid = enc_hit;
            rsp_d.multi = enc_hit && enc_multi;
            rsp_d.index = '0;
            if (enc_hit) rsp_d.index[IDX_W-1:0] = enc_index;
        end
    end

    // The data array deliberately has no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (write_i) data_q[write_index_i] <= write_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            count_q      <= '0;
            read_valid_q <= 1'b0;
            read_value_q <= '0;
            rsp_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            count_q      <= count_d;
            read_valid_q <= read_valid_d;
            read_value_q <= read_value_d;
            rsp_q        <= rsp_d;
        end
    end

    assign read_valid_o   = read_valid_q;
    assign read_value_o   = read_value_q;
    assign search_valid_o = rsp_q.valid;
    assign search_multi_o = rsp_q.multi;
    assign search_index_o = IDX_W'(rsp_q.index);
    assign count_o        = count_q;
    assign full_o         = (count_q == (IDX_W + 1)'(DEPTH));

endmodule

// File: tb/tb_cam_param.sv
// ---------------------------------------------------------------------------
// tb_cam_param
// Self-checking bench for cam_param at the default 32 x 32 geometry.
// Table of hand-derived vectors plus a few hand-written sequences; the
// expected response of each driven vector is queued and checked after the
// clock edge that produces it. Honours CAM_PARAM_MASK_EN when defined.
// ---------------------------------------------------------------------------
module tb_cam_param;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             read_i = 1'b0;
    logic [IDX_W-1:0] read_index_i = '0;
    logic             write_i = 1'b0;
    logic [IDX_W-1:0] write_index_i = '0;
    logic [WIDTH-1:0] write_data_i = '0;
    logic             inval_i = 1'b0;
    logic [IDX_W-1:0] inval_index_i = '0;
    logic             search_i = 1'b0;
    logic [WIDTH-1:0] search_data_i = '0;
    logic [WIDTH-1:0] search_mask = '0;
    logic             read_valid_o;
    logic [WIDTH-1:0] read_value_o;
    logic             search_valid_o;
    logic [IDX_W-1:0] search_index_o;
    logic             search_multi_o;
    logic [IDX_W:0]   count_o;
    logic             full_o;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    cam_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .read_i         (read_i),
        .read_index_i   (read_index_i),
        .write_i        (write_i),
        .write_index_i  (write_index_i),
        .write_data_i   (write_data_i),
        .inval_i        (inval_i),
        .inval_index_i  (inval_index_i),
        .search_i       (search_i),
        .search_data_i  (search_data_i),
`ifdef CAM_PARAM_MASK_EN
        .search_mask_i  (search_mask),
`endif
        .read_valid_o   (read_valid_o),
        .read_value_o   (read_value_o),
        .search_valid_o (search_valid_o),
        .search_index_o (search_index_o),
        .search_multi_o (search_multi_o),
        .count_o        (count_o),
        .full_o         (full_o)
    );

    typedef struct {
        logic             rd;
        logic [IDX_W-1:0] ridx;
        logic             wr;
        logic [IDX_W-1:0] widx;
        logic [WIDTH-1:0] wdata;
        logic             inv;
        logic [IDX_W-1:0] iidx;
        logic             srch;
        logic [WIDTH-1:0] sdata;
        logic [WIDTH-1:0] smask;
        logic             erv;
        logic [WIDTH-1:0] erval;
        logic             esv;
        logic [IDX_W-1:0] esidx;
        logic             esm;
        logic [IDX_W:0]   ecnt;
        logic             efull;
    } vec_t;

    typedef struct {
        int               tag;
        logic             erv;
        logic [WIDTH-1:0] erval;
        logic             esv;
        logic [IDX_W-1:0] esidx;
        logic             esm;
        logic [IDX_W:0]   ecnt;
        logic             efull;
    } exp_t;

    exp_t expQ[$];
    vec_t tbl[18];
    int   total = 0;
    int   bad = 0;

    // Packs one vector record from positional fields
    function automatic vec_t mk(
        input logic rd, input logic [IDX_W-1:0] ridx,
        input logic wr, input logic [IDX_W-1:0] widx, input logic [WIDTH-1:0] wdata,
        input logic inv, input logic [IDX_W-1:0] iidx,
        input logic srch, input logic [WIDTH-1:0] sdata, input logic [WIDTH-1:0] smask,
        input logic erv, input logic [WIDTH-1:0] erval,
        input logic esv, input logic [IDX_W-1:0] esidx, input logic esm,
        input logic [IDX_W:0] ecnt, input logic efull);
        vec_t v;
        v.rd = rd; v.ridx = ridx; v.wr = wr; v.widx = widx; v.wdata = wdata;
        v.inv = inv; v.iidx = iidx; v.srch = srch; v.sdata = sdata; v.smask = smask;
        v.erv = erv; v.erval = erval; v.esv = esv; v.esidx = esidx; v.esm = esm;
        v.ecnt = ecnt; v.efull = efull;
        return v;
    endfunction

    // One comparison: counts it and reports a FAIL line on disagreement
    task automatic cmp(input string name, input int tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s (vec %0d): actual=0x%0h required=0x%0h", name, tag, act, req);
        end
    endtask

    // Pops the oldest expected response and compares it with the DUT outputs
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: actual=0 required=1 entries");
            return;
        end
        e = expQ.pop_front();
        cmp("read_valid",   e.tag, WIDTH'(read_valid_o),   WIDTH'(e.erv));
        cmp("read_value",   e.tag, read_value_o,           e.erval);
        cmp("search_valid", e.tag, WIDTH'(search_valid_o), WIDTH'(e.esv));
        cmp("search_index", e.tag, WIDTH'(search_index_o), WIDTH'(e.esidx));
        cmp("search_multi", e.tag, WIDTH'(search_multi_o), WIDTH'(e.esm));
        cmp("count",        e.tag, WIDTH'(count_o),        WIDTH'(e.ecnt));
        cmp("full",         e.tag, WIDTH'(full_o),         WIDTH'(e.efull));
    endtask

    // Drives a vector mid-cycle, queues its expectation, checks after the edge
    task automatic applyStimulus(input vec_t v, input int tag);
        exp_t e;
        @(negedge clk);
        read_i = v.rd;    read_index_i = v.ridx;
        write_i = v.wr;   write_index_i = v.widx;  write_data_i = v.wdata;
        inval_i = v.inv;  inval_index_i = v.iidx;
        search_i = v.srch; search_data_i = v.sdata; search_mask = v.smask;
        e.tag = tag; e.erv = v.erv; e.erval = v.erval; e.esv = v.esv;
        e.esidx = v.esidx; e.esm = v.esm; e.ecnt = v.ecnt; e.efull = v.efull;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Watchdog so a stuck run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, table of vectors, fill, masking, mid-run reset
    initial begin
        logic [DEPTH-1:0] modelValid;
        logic [IDX_W:0]   expCnt;
        vec_t             v;

        //              rd ridx wr widx wdata          inv iidx srch sdata          mask | rv rval           sv sidx sm cnt full
        tbl[0]  = mk(1, 5,  0, 0,  32'h0,         0, 0, 1, 32'h0,         '0, 0, 32'h0,         0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0,  1, 3,  32'hDEADBEEF,  0, 0, 0, 32'h0,         '0, 0, 32'h0,         0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 3,  0, 0,  32'h0,         0, 0, 1, 32'hDEADBEEF,  '0, 1, 32'hDEADBEEF,  1, 3, 0, 1, 0);
        tbl[3]  = mk(0, 0,  1, 7,  32'h1234,      0, 0, 0, 32'h0,         '0, 0, 32'hDEADBEEF,  0, 3, 0, 2, 0);
        tbl[4]  = mk(0, 0,  1, 2,  32'h1234,      0, 0, 0, 32'h0,         '0, 0, 32'hDEADBEEF,  0, 3, 0, 3, 0);
        tbl[5]  = mk(0, 0,  0, 0,  32'h0,         0, 0, 1, 32'h1234,      '0, 0, 32'hDEADBEEF,  1, 2, 1, 3, 0);
        tbl[6]  = mk(0, 0,  1, 4,  32'hA5,        0, 0, 1, 32'hA5,        '0, 0, 32'hDEADBEEF,  0, 0, 0, 4, 0);
        tbl[7]  = mk(0, 0,  0, 0,  32'h0,         0, 0, 1, 32'hA5,        '0, 0, 32'hDEADBEEF,  1, 4, 0, 4, 0);
        tbl[8]  = mk(0, 0,  1, 9,  32'h99,        1, 9, 0, 32'h0,         '0, 0, 32'hDEADBEEF,  0, 4, 0, 5, 0);
        tbl[9]  = mk(1, 9,  0, 0,  32'h0,         0, 0, 0, 32'h0,         '0, 1, 32'h99,        0, 4, 0, 5, 0);
        tbl[10] = mk(0, 0,  0, 0,  32'h0,         1, 9, 0, 32'h0,         '0, 0, 32'h99,        0, 4, 0, 4, 0);
        tbl[11] = mk(0, 0,  0, 0,  32'h0,         0, 0, 1, 32'h99,        '0, 0, 32'h99,        0, 0, 0, 4, 0);
        tbl[12] = mk(1, 9,  0, 0,  32'h0,         0, 0, 0, 32'h0,         '0, 0, 32'h0,         0, 0, 0, 4, 0);
        tbl[13] = mk(0, 0,  0, 0,  32'h0,         1, 9, 0, 32'h0,         '0, 0, 32'h0,         0, 0, 0, 4, 0);
        tbl[14] = mk(0, 0,  1, 10, 32'h77,        1, 3, 1, 32'hDEADBEEF,  '0, 0, 32'h0,         1, 3, 0, 4, 0);
        tbl[15] = mk(1, 10, 0, 0,  32'h0,         0, 0, 1, 32'hDEADBEEF,  '0, 1, 32'h77,        0, 0, 0, 4, 0);
        tbl[16] = mk(0, 0,  1, 2,  32'h5555,      0, 0, 0, 32'h0,         '0, 0, 32'h77,        0, 0, 0, 4, 0);
        tbl[17] = mk(0, 0,  0, 0,  32'h0,         0, 0, 1, 32'h1234,      '0, 0, 32'h77,        1, 7, 0, 4, 0);

        // Reset state: every output low
        repeat (2) @(negedge clk);
        cmp("reset_read_valid",   -1, WIDTH'(read_valid_o),   '0);
        cmp("reset_search_valid", -1, WIDTH'(search_valid_o), '0);
        cmp("reset_count",        -1, WIDTH'(count_o),        '0);
        cmp("reset_full",         -1, WIDTH'(full_o),         '0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) applyStimulus(tbl[i], i);

        // Fill every entry; valid after the table are 2, 4, 7 and 10
        modelValid = DEPTH'(32'h0000_0494);
        expCnt     = 6'd4;
        for (int i = 0; i < DEPTH; i++) begin
            if (!modelValid[i]) expCnt = expCnt + 1'b1;
            modelValid[i] = 1'b1;
            v = mk(0, 0, 1, IDX_W'(i), 32'h1000 + i, 0, 0, 0, 32'h0, '0,
                   0, 32'h77, 0, 7, 0, expCnt, (expCnt == 6'd32));
            applyStimulus(v, 100 + i);
        end

        applyStimulus(mk(1, 5, 0, 0, 32'h0, 0, 0, 1, 32'h1005, '0,
                         1, 32'h1005, 1, 5, 0, 32, 1), 200);
        applyStimulus(mk(0, 0, 1, 3, 32'h1234BEEF, 0, 0, 0, 32'h0, '0,
                         0, 32'h1005, 0, 5, 0, 32, 1), 201);
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0000BEEF, '0,
                         0, 32'h1005, 0, 0, 0, 32, 1), 202);
`ifdef CAM_PARAM_MASK_EN
        // Upper half don't-care: only entry 3 has 0xBEEF in the low half
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0000BEEF, 32'hFFFF0000,
                         0, 32'h1005, 1, 3, 0, 32, 1), 203);
        // All-ones mask matches every valid entry
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'hFFFFFFFF,
                         0, 32'h1005, 1, 0, 1, 32, 1), 204);
`endif

        // Reset in the middle of an in-flight read and search
        @(negedge clk);
        read_i = 1'b1; read_index_i = 5; search_i = 1'b1; search_data_i = 32'h1005;
        write_i = 1'b0; inval_i = 1'b0; search_mask = '0;
        #2 rst = 1'b0;
        #1;
        cmp("midrst_read_valid",   300, WIDTH'(read_valid_o),   '0);
        cmp("midrst_read_value",   300, read_value_o,           '0);
        cmp("midrst_search_valid", 300, WIDTH'(search_valid_o), '0);
        cmp("midrst_search_index", 300, WIDTH'(search_index_o), '0);
        cmp("midrst_count",        300, WIDTH'(count_o),        '0);
        cmp("midrst_full",         300, WIDTH'(full_o),         '0);
        @(posedge clk);
        #1;
        cmp("midrst_edge_read_valid",   301, WIDTH'(read_valid_o),   '0);
        cmp("midrst_edge_search_valid", 301, WIDTH'(search_valid_o), '0);
        @(negedge clk);
        read_i = 1'b0; search_i = 1'b0;
        rst = 1'b1;

        // First search after reset misses even though the data is still there
        applyStimulus(mk(1, 5, 0, 0, 32'h0, 0, 0, 1, 32'h1005, '0,
                         0, 32'h0, 0, 0, 0, 0, 0), 302);
        applyStimulus(mk(0, 0, 1, 6, 32'h66, 0, 0, 1, 32'h66, '0,
                         0, 32'h0, 0, 0, 0, 1, 0), 303);
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h66, '0,
                         0, 32'h0, 1, 6, 0, 1, 0), 304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
